// File: rtl/closest_hit_resolver.sv
// closest_hit_resolver: per-lane result FIFOs, picks nearest signed tmin hit (lowest lane on tie); optional RESOLVER_TAG_CHECK_EN.
// Latency 2 edges accept->out_valid, 1 pixel/cycle; out_ready low stalls pops, a full lane FIFO drops its in_ready.
module hit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module closest_hit_resolver #(
  parameter int                 WIDTH        = 16,
  parameter int                 TAG_SIZE     = 16,
  parameter int                 OBJECT_COUNT = 3,
  parameter int                 FIFO_DEPTH   = 4,
  parameter int                 PIXEL_WIDTH  = 64,
  parameter int                 PIXEL_HEIGHT = 64,
  parameter logic [WIDTH-1:0]   MAX          = 16'h7FFF,
  parameter logic [23:0]        BG_COLOR     = 24'h000000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [OBJECT_COUNT-1:0]          in_valid,
  output logic [OBJECT_COUNT-1:0]          in_ready,
  input  logic [OBJECT_COUNT*TAG_SIZE-1:0] in_tag,
  input  logic [OBJECT_COUNT-1:0]          in_hit,
  input  logic [OBJECT_COUNT*WIDTH-1:0]    in_tmin,
  input  logic [OBJECT_COUNT*24-1:0]       in_color,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [TAG_SIZE-1:0]              out_tag,
  output logic                             out_hit,
  output logic [WIDTH-1:0]                 out_tmin,
  output logic [23:0]                      out_color,
  output logic                             frame_done,
  output logic                             tag_error
);
  localparam int PIX_TOTAL = PIXEL_WIDTH * PIXEL_HEIGHT;
  localparam int CW        = $clog2(PIX_TOTAL);

  typedef struct packed {
    logic [TAG_SIZE-1:0] tag;
    logic                hit;
    logic [WIDTH-1:0]    tmin;
    logic [23:0]         color;
  } entry_t;

  entry_t                  head [OBJECT_COUNT];
  logic [OBJECT_COUNT-1:0] full, empty;
  logic                    pop, load, tags_ok, handshake;
  logic                    win_found;
  logic [WIDTH-1:0]        win_tmin;
  logic [23:0]             win_color;
  logic [CW-1:0]           pix_cnt;

  for (genvar i = 0; i < OBJECT_COUNT; i++) begin : g_lane
    entry_t push_dat;
    assign push_dat    = '{tag:   in_tag[i*TAG_SIZE +: TAG_SIZE],
                           hit:   in_hit[i],
                           tmin:  in_tmin[i*WIDTH +: WIDTH],
                           color: in_color[i*24 +: 24]};
    assign in_ready[i] = !full[i];

    hit_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (in_valid[i]),
      .push_dat (push_dat),
      .pop      (pop),
      .pop_dat  (head[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );
  end

  assign pop       = !(|empty) && (!out_valid || out_ready);
  assign load      = pop && tags_ok;
  assign handshake = out_valid && out_ready;

  // Strict less-than keeps the lowest lane index on equal tmin.
  always_comb begin
    win_found = 1'b0;
    win_tmin  = MAX;
    win_color = BG_COLOR;
    for (int i = 0; i < OBJECT_COUNT; i++) begin
      if (head[i].hit && (!win_found || ($signed(head[i].tmin) < $signed(win_tmin)))) begin
        win_found = 1'b1;
        win_tmin  = head[i].tmin;
        win_color = head[i].color;
      end
    end
  end

`ifdef RESOLVER_TAG_CHECK_EN
  always_comb begin
    tags_ok = 1'b1;
    for (int i = 1; i < OBJECT_COUNT; i++)
      if (head[i].tag != head[0].tag) tags_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)              tag_error <= 1'b0;
    else if (pop && !tags_ok) tag_error <= 1'b1;
  end
`else
  assign tags_ok   = 1'b1;
  assign tag_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_hit   <= 1'b0;
      out_tmin  <= MAX;
      out_color <= BG_COLOR;
    end else if (load) begin
      out_valid <= 1'b1;
      out_tag   <= head[0].tag;
      out_hit   <= win_found;
      out_tmin  <= win_tmin;
      out_color <= win_color;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= handshake && (pix_cnt == CW'(PIX_TOTAL - 1));
      if (handshake) pix_cnt <= (pix_cnt == CW'(PIX_TOTAL - 1)) ? '0 : pix_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_closest_hit_resolver.sv
// Scoreboard bench for closest_hit_resolver: directed vectors push expected pixels, a monitor pops and compares.
module tb_closest_hit_resolver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_ready;
  logic [47:0] in_tag = '0;
  logic [2:0]  in_hit = '0;
  logic [47:0] in_tmin = '0;
  logic [71:0] in_color = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_tag;
  logic        out_hit;
  logic [15:0] out_tmin;
  logic [23:0] out_color;
  logic        frame_done;
  logic        tag_error;

  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          hs_base = 0;
  logic [56:0] exp_q [$];
  int          fd_q [$];
  logic [56:0] exp_tab [5];

  closest_hit_resolver dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_hit(in_hit),
    .in_tmin(in_tmin), .in_color(in_color),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_hit(out_hit),
    .out_tmin(out_tmin), .out_color(out_color),
    .frame_done(frame_done), .tag_error(tag_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
  task automatic send(input logic [47:0] tag, input logic [2:0] hit, input logic [47:0] tmin,
                      input logic [71:0] color, input bit expect_it, input logic [56:0] exp);
    int cnt;
    in_valid = 3'b111;
    in_tag   = tag;
    in_hit   = hit;
    in_tmin  = tmin;
    in_color = color;
    cnt = 0;
    while (in_ready !== 3'b111 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 500) check("send_accept_timeout", 64'(in_ready), 64'h7);
    if (expect_it) exp_q.push_back(exp);
    @(negedge clk);
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    exp_tab[0] = {16'd20, 1'b1, 16'h1000, 24'hAA0000};
    exp_tab[1] = {16'd21, 1'b1, 16'h1000, 24'h00BB00};
    exp_tab[2] = {16'd22, 1'b1, 16'h1000, 24'h0000CC};
    exp_tab[3] = {16'd23, 1'b1, 16'hF000, 24'hAA0000};
    exp_tab[4] = {16'd24, 1'b1, 16'h1000, 24'hAA0000};

    fork
      begin : stimulus
        logic [47:0] tm [5];
        tm[0] = {16'h3000, 16'h2000, 16'h1000};
        tm[1] = {16'h3000, 16'h1000, 16'h2000};
        tm[2] = {16'h1000, 16'h2000, 16'h3000};
        tm[3] = {16'h2000, 16'h1000, 16'hF000};
        tm[4] = {16'h1000, 16'h1000, 16'h1000};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_hit", 64'(out_hit), 64'd0);
        check("rst_out_tmin", 64'(out_tmin), 64'h7FFF);
        check("rst_out_color", 64'(out_color), 64'h000000);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_tag_error", 64'(tag_error), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'h7);

        // Basic resolve plus two-edge latency.
        out_ready = 1'b1;
        in_valid  = 3'b111;
        in_tag    = {3{16'd5}};
        in_hit    = 3'b011;
        in_tmin   = {16'h0800, 16'h1000, 16'h2000};
        in_color  = {24'h0000FF, 24'h00FF00, 24'hFF0000};
        exp_q.push_back({16'd5, 1'b1, 16'h1000, 24'h00FF00});
        @(negedge clk);
        in_valid = '0;
        check("latency_edge1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_edge2_out_valid", 64'(out_valid), 64'd1);
        drain();

        send({3{16'd9}}, 3'b000, {16'h0100, 16'h0200, 16'h0300},
             {24'h111111, 24'h222222, 24'h333333}, 1'b1, {16'd9, 1'b0, 16'h7FFF, 24'h000000});
        in_valid = '0;
        drain();

        // Tie on tmin between lanes 0 and 2; the nearer miss on lane 1 must be ignored.
        send({3{16'd3}}, 3'b101, {16'h1800, 16'h0100, 16'h1800},
             {24'hABCDEF, 24'h654321, 24'h123456}, 1'b1, {16'd3, 1'b1, 16'h1800, 24'h123456});
        in_valid = '0;
        drain();

`ifdef RESOLVER_TAG_CHECK_EN
        send({16'd6, 16'd7, 16'd6}, 3'b111, {16'h0100, 16'h0200, 16'h0300},
             {24'h1, 24'h2, 24'h3}, 1'b0, '0);
        in_valid = '0;
        repeat (4) @(negedge clk);
        check("tagchk_tag_error", 64'(tag_error), 64'd1);
        check("tagchk_no_output", 64'(out_valid), 64'd0);
`else
        check("notagchk_tag_error", 64'(tag_error), 64'd0);
`endif

        // Backpressure: fill output register plus all four FIFO slots.
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++)
          send({3{16'(20 + j)}}, 3'b111, tm[j], {24'h0000CC, 24'h00BB00, 24'hAA0000}, 1'b1, exp_tab[j]);
        in_valid = '0;
        @(negedge clk);
        check("bp_in_ready_full", 64'(in_ready), 64'h0);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_pixel", {7'd0, out_tag, out_hit, out_tmin, out_color}, 64'(exp_tab[0]));
        out_ready = 1'b1;
        drain();

        // Reset mid-stream discards buffered sets.
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++)
          send({3{16'hDEAD}}, 3'b111, tm[0], {24'h1, 24'h2, 24'h3}, 1'b0, '0);
        in_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'h7);
        check("midrst_tag_error", 64'(tag_error), 64'd0);
        hs_base = hs_cnt;
        fd_q.delete();

        // Two full frames back to back.
        out_ready = 1'b1;
        for (int i = 0; i < 8192; i++)
          send({3{16'(i)}}, 3'b110, {16'h0900, 16'h0100, 16'h0200},
               {24'h0, 24'(i), 24'h0}, 1'b1, {16'(i), 1'b1, 16'h0100, 24'(i)});
        in_valid = '0;
        drain();
        repeat (3) @(negedge clk);
        check("frame_done_count", 64'(fd_q.size()), 64'd2);
        if (fd_q.size() >= 1) check("frame_done_first_at", 64'(fd_q[0] - hs_base), 64'd4096);
        if (fd_q.size() >= 2) check("frame_done_second_at", 64'(fd_q[1] - hs_base), 64'd8192);
      end
      begin : monitor
        logic [56:0] e;
        forever begin
          @(negedge clk);
          #1;
          if (frame_done) fd_q.push_back(hs_cnt);
          if (!reset && out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_pixel: got %h expected none", {out_tag, out_hit, out_tmin, out_color});
            end else begin
              e = exp_q.pop_front();
              check("pixel", {7'd0, out_tag, out_hit, out_tmin, out_color}, 64'(e));
            end
          end
        end
      end
      begin : watchdog
        repeat (60000) @(posedge clk);
        check("global_timeout", 64'd1, 64'd0);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
